// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential IEEE-754 single-precision divider
// Radix-2 restoring mantissa divider, one quotient bit per clock, round-to-nearest-even.
module fp_div_seq #(
  parameter int width = 32,
  parameter int ITER  = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] result,
  output logic             overflow,
  output logic             underflow,
  output logic             div_by_zero,
  output logic             invalid
);

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_ROUND, S_DONE} state_t;
  typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO, SP_DBZ} spec_t;

  localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

  state_t             state_q;
  spec_t              spec_q;
  logic [4:0]         cnt_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [22:0]        frac_q;
  logic [23:0]        mb_q;
  logic [25:0]        r_q, q_q;
  logic               busy_q, done_q;
  logic [width-1:0]   result_q;
  logic               ovf_q, unf_q, dbz_q, inv_q;

  // Operand decode (denormals flush to zero)
  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [23:0]       ma_dec, mb_dec;
  logic signed [9:0] exp_dec;
  spec_t             spec_dec;

  always_comb begin
    a_zero  = (a[30:23] == 8'h00);
    b_zero  = (b[30:23] == 8'h00);
    a_inf   = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf   = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan   = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan   = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    ma_dec  = a_zero ? 24'd0 : {1'b1, a[22:0]};
    mb_dec  = b_zero ? 24'd0 : {1'b1, b[22:0]};
    // Biased for the q[25]=0 case; the normaliser adds one when q[25]=1
    exp_dec = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd126;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) spec_dec = SP_NAN;
    else if (a_inf)  spec_dec = SP_INF;
    else if (b_inf)  spec_dec = SP_ZERO;
    else if (b_zero) spec_dec = SP_DBZ;
    else if (a_zero) spec_dec = SP_ZERO;
    else             spec_dec = SP_NONE;
  end

  // One restoring-division step
  logic        r_ge;
  logic [25:0] r_sub, r_d, q_d;

  always_comb begin
    r_ge  = (r_q >= {2'b00, mb_q});
    r_sub = r_ge ? (r_q - {2'b00, mb_q}) : r_q;
    r_d   = r_sub << 1;
    q_d   = {q_q[24:0], r_ge};
  end

  // Normalise and round; the hidden bit is implicit, so a carry out of the
  // fraction means the mantissa became 2.0 and renormalises to 1.0
  logic [22:0]       norm_frac;
  logic              guard, sticky, round_up;
  logic signed [9:0] norm_exp, rnd_exp;
  logic [23:0]       frac_sum;

  always_comb begin
    if (q_q[25]) begin
      norm_frac = q_q[24:2];
      guard     = q_q[1];
      sticky    = q_q[0] | (r_q != 26'd0);
      norm_exp  = exp_q + 10'sd1;
    end else begin
      norm_frac = q_q[23:1];
      guard     = q_q[0];
      sticky    = (r_q != 26'd0);
      norm_exp  = exp_q;
    end
    round_up = guard & (sticky | norm_frac[0]);
    frac_sum = {1'b0, norm_frac} + {23'd0, round_up};
    rnd_exp  = frac_sum[23] ? (norm_exp + 10'sd1) : norm_exp;
  end

  // Final packing with special-case override
  logic [width-1:0] res_d;
  logic             ovf_d, unf_d, dbz_d, inv_d;

  always_comb begin
    res_d = {sign_q, exp_q[7:0], frac_q};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    dbz_d = 1'b0;
    inv_d = 1'b0;
    case (spec_q)
      SP_NAN:  begin res_d = 32'h7FC0_0000; inv_d = 1'b1; end
      SP_INF:  res_d = {sign_q, 8'hFF, 23'd0};
      SP_ZERO: res_d = {sign_q, 31'd0};
      SP_DBZ:  begin res_d = {sign_q, 8'hFF, 23'd0}; dbz_d = 1'b1; end
      default: begin
        if (exp_q >= 10'sd255) begin
          res_d = {sign_q, 8'hFF, 23'd0};
          ovf_d = 1'b1;
        end else if (exp_q <= 10'sd0) begin
          res_d = {sign_q, 31'd0};
          unf_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      spec_q   <= SP_NONE;
      cnt_q    <= 5'd0;
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      frac_q   <= 23'd0;
      mb_q     <= 24'd0;
      r_q      <= 26'd0;
      q_q      <= 26'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dbz_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sign_q  <= a[31] ^ b[31];
            spec_q  <= spec_dec;
            exp_q   <= exp_dec;
            r_q     <= {2'b00, ma_dec};
            mb_q    <= mb_dec;
            q_q     <= 26'd0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b1;
            state_q <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) state_q <= S_ROUND;
        end
        S_ROUND: begin
          frac_q  <= frac_sum[22:0];
          exp_q   <= rnd_exp;
          state_q <= S_DONE;
        end
        S_DONE: begin
          result_q <= res_d;
          ovf_q    <= ovf_d;
          unf_q    <= unf_d;
          dbz_q    <= dbz_d;
          inv_q    <= inv_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign div_by_zero = dbz_q;
  assign invalid     = inv_q;

endmodule
